// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the LED grayscale shifter.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_CHIPS     = 3;
  localparam int unsigned DEF_SCLK_DIV  = 2;
  localparam int unsigned DEF_WRTGS_LEN = 1;
  localparam int unsigned DEF_LATGS_LEN = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_gs_shifter_if.sv
// Grayscale word stream (valid/ready) from the frame-buffer reader.
interface led_gs_shifter_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/led_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module led_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/led_gs_shifter.sv
// Serialises grayscale words onto a daisy-chained LED driver (SIN/SCLK/LAT).
// Optional LED_HPS_OVERRIDE_EN adds HPS pass-through of the driver pins in IDLE.
module led_gs_shifter
  import led_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned CHIPS     = DEF_CHIPS,
  parameter int unsigned SCLK_DIV  = DEF_SCLK_DIV,
  parameter int unsigned WRTGS_LEN = DEF_WRTGS_LEN,
  parameter int unsigned LATGS_LEN = DEF_LATGS_LEN
) (
  input  logic             clk,
  input  logic             reset_n,
  led_gs_shifter_if.slave  s_bus,
  output logic             sclk,
  output logic             sin,
  output logic             lat,
  input  logic             sout,
  output logic             hps_sout,
  output logic             frame_done,
  output logic             last_err
`ifdef LED_HPS_OVERRIDE_EN
  ,
  input  logic             hps_override,
  input  logic             hps_fc_clk,
  input  logic             hps_fc_data,
  input  logic             hps_fc_lat
`endif
);
  localparam int unsigned BW = cnt_w(DATA_W);
  localparam int unsigned DW = cnt_w(SCLK_DIV);
  localparam int unsigned GW = cnt_w(CHIPS);

  state_t            state, state_nx;
  logic [DATA_W-1:0] sreg;
  logic [BW-1:0]     bitcnt;
  logic [DW-1:0]     div;
  logic [GW-1:0]     grp, grp_upd, grp_eff;
  logic [BW:0]       lat_len, len_nx;
  logic              last_q, rdy_q, err_q;
  logic              accept, phase_end, ovr;
  logic              sclk_i, sin_i, lat_i;

  led_sync2 u_sout_sync (.clk(clk), .reset_n(reset_n), .d(sout), .q(hps_sout));

`ifdef LED_HPS_OVERRIDE_EN
  logic ovr_s;
  led_sync2 u_ovr_sync (.clk(clk), .reset_n(reset_n), .d(hps_override), .q(ovr_s));
  assign ovr = ovr_s;
`else
  assign ovr = 1'b0;
`endif

  // DONE also accepts so a back-to-back stream keeps the 2*SCLK_DIV*DATA_W+1 word period;
  // the group counter seen by that accept is the value DONE is writing back.
  assign s_bus.s_ready = rdy_q && !ovr && (state == IDLE || state == DONE);
  assign accept        = s_bus.s_valid && s_bus.s_ready;
  assign phase_end     = (div == DW'(SCLK_DIV - 1));
  assign grp_upd       = (lat_len != '0) ? '0 : grp + 1'b1;
  assign grp_eff       = (state == DONE) ? grp_upd : grp;
  assign len_nx        = s_bus.s_last ? (BW+1)'(LATGS_LEN)
                       : (grp_eff == GW'(CHIPS - 1)) ? (BW+1)'(WRTGS_LEN) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_nx = SHIFT_HI;
      SHIFT_HI: if (phase_end) state_nx = (bitcnt == '0) ? DONE : SHIFT_LO;
      DONE:     state_nx = accept ? SHIFT_LO : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg    <= '0;
      bitcnt  <= '0;
      div     <= '0;
      grp     <= '0;
      lat_len <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (state == DONE) grp <= grp_upd;
      if (accept) begin
        sreg    <= s_bus.s_data;
        bitcnt  <= BW'(DATA_W - 1);
        div     <= '0;
        last_q  <= s_bus.s_last;
        lat_len <= len_nx;
        if (s_bus.s_last && grp_eff != GW'(CHIPS - 1)) err_q <= 1'b1;
      end else if (state == SHIFT_LO || state == SHIFT_HI) begin
        div <= phase_end ? '0 : div + 1'b1;
        if (state == SHIFT_HI && phase_end && bitcnt != '0) bitcnt <= bitcnt - 1'b1;
      end
    end
  end

  assign sclk_i     = (state == SHIFT_HI);
  assign sin_i      = sreg[bitcnt];
  assign lat_i      = (state == SHIFT_LO || state == SHIFT_HI) && ({1'b0, bitcnt} < lat_len);
  assign frame_done = (state == DONE) && last_q;
  assign last_err   = err_q;

`ifdef LED_HPS_OVERRIDE_EN
  always_comb begin
    sclk = sclk_i;
    sin  = sin_i;
    lat  = lat_i;
    if (state == IDLE && ovr) begin
      sclk = hps_fc_clk;
      sin  = hps_fc_data;
      lat  = hps_fc_lat;
    end
  end
`else
  assign sclk = sclk_i;
  assign sin  = sin_i;
  assign lat  = lat_i;
`endif
endmodule
